// File: rtl/histeq_pkg.sv
// Shared types and defaults for the histogram-equalisation controller.
package histeq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACCUM,
        GAP
    } state_t;

    localparam int unsigned CNT_W       = 19;
    localparam int unsigned MAX_PIX_DEF = 307200;
    localparam int unsigned GAP_CYC_DEF = 2;

endpackage

// File: rtl/histeq_gap_timer.sv
// Load/decrement down-counter with a zero flag; times the inter-frame gap.
module histeq_gap_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         erst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/histeq_ctrl.sv
// Frame controller for histogram equalisation: accumulation window, LUT read path.
// Optional frame statistics (pix_cnt, ovf) when HISTEQ_CTRL_STAT_EN is defined.
module histeq_ctrl
    import histeq_pkg::*;
#(
    parameter int unsigned MAX_PIX = MAX_PIX_DEF,
    parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
    input  logic             clk,
    input  logic             erst,
    input  logic             enable,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic             pix_eof,
    input  logic [7:0]       pix_y,
    output logic             wsig,
    output logic             valid,
    output logic [7:0]       ydata,
    output logic             rsig,
    output logic [7:0]       iydata,
    output logic             map_valid,
    output logic             busy,
`ifdef HISTEQ_CTRL_STAT_EN
    output logic [CNT_W-1:0] pix_cnt,
    output logic             ovf,
`endif
    output logic             frame_done
);

    localparam int unsigned      TW     = $clog2(GAP_CYC) + 1;
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PIX);
    localparam logic [TW-1:0]    GAP_LD = TW'(GAP_CYC - 1);

    state_t           state, state_n;
    logic             close_pend;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             start, accept, hit, closing;
    logic             gap_zero, gap_done, in_gap;

    // ACCUM outlives the closing pixel by one cycle so wsig still covers its
    // delayed valid; inputs seen while close_pend is set are dropped.
    always_comb begin
        start   = (state == WAIT_SOF) && enable && pix_valid && pix_sof;
        accept  = start || ((state == ACCUM) && !close_pend && pix_valid);
        cnt_n   = start ? CNT_W'(1) : cnt + 1'b1;
        hit     = accept && (cnt_n == MAX_C);
        closing = (state == ACCUM) && close_pend;
        in_gap  = (state == GAP);
        gap_done = in_gap && gap_zero;
        state_n = state;
        case (state)
            IDLE:     if (enable) state_n = WAIT_SOF;
            WAIT_SOF: begin
                if (start)        state_n = ACCUM;
                else if (!enable) state_n = IDLE;
            end
            ACCUM:    if (close_pend) state_n = GAP;
            GAP:      if (gap_zero) state_n = enable ? WAIT_SOF : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    histeq_gap_timer #(
        .W (TW)
    ) u_gap_timer (
        .clk      (clk),
        .erst     (erst),
        .load     (closing),
        .load_val (GAP_LD),
        .dec      (in_gap),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            state      <= IDLE;
            close_pend <= 1'b0;
            cnt        <= '0;
            wsig       <= 1'b0;
            valid      <= 1'b0;
            ydata      <= '0;
            rsig       <= 1'b0;
            iydata     <= '0;
            map_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef HISTEQ_CTRL_STAT_EN
            pix_cnt    <= '0;
            ovf        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            wsig       <= (state_n == ACCUM);
            busy       <= (state_n != IDLE);
            valid      <= accept;
            ydata      <= pix_y;
            frame_done <= closing;
            map_valid  <= pix_valid && rsig;
            if (pix_valid) iydata <= pix_y;
            if (accept) begin
                cnt        <= cnt_n;
                close_pend <= pix_eof || hit;
            end else if (closing) begin
                close_pend <= 1'b0;
            end
            if (gap_done) rsig <= 1'b1;
`ifdef HISTEQ_CTRL_STAT_EN
            if (closing) pix_cnt <= cnt;
            if (hit && !pix_eof) ovf <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_histeq_ctrl.sv
// Directed self-checking bench for histeq_ctrl (MAX_PIX=5, GAP_CYC=2).
module tb_histeq_ctrl;

    logic        clk = 1'b0;
    logic        erst = 1'b0;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_eof = 1'b0;
    logic [7:0]  pix_y = '0;
    logic        wsig, valid, rsig, map_valid, busy, frame_done;
    logic [7:0]  ydata, iydata;
`ifdef HISTEQ_CTRL_STAT_EN
    logic [18:0] pix_cnt;
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    histeq_ctrl #(
        .MAX_PIX (5),
        .GAP_CYC (2)
    ) dut (
        .clk        (clk),
        .erst       (erst),
        .enable     (enable),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_eof    (pix_eof),
        .pix_y      (pix_y),
        .wsig       (wsig),
        .valid      (valid),
        .ydata      (ydata),
        .rsig       (rsig),
        .iydata     (iydata),
        .map_valid  (map_valid),
        .busy       (busy),
`ifdef HISTEQ_CTRL_STAT_EN
        .pix_cnt    (pix_cnt),
        .ovf        (ovf),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one input cycle, then sample 1 time unit after the clock edge.
    task automatic pix(input logic v, input logic s, input logic e, input logic [7:0] y);
        pix_valid = v;
        pix_sof   = s;
        pix_eof   = e;
        pix_y     = y;
        @(posedge clk);
        #1;
    endtask

    task automatic hist(input string tag, input logic w, input logic v, input logic [7:0] y,
                        input logic fd);
        check({tag, ".wsig"}, 32'(wsig), 32'(w));
        check({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) check({tag, ".ydata"}, 32'(ydata), 32'(y));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    initial begin
        #1;
        check("rst.wsig", 32'(wsig), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.rsig", 32'(rsig), 0);
        check("rst.iydata", 32'(iydata), 0);
        check("rst.map_valid", 32'(map_valid), 0);
        @(posedge clk);
        #1;
        erst = 1'b1;
        enable = 1'b1;

        // Frame 1: stray pixel before sof, then 10,20,20,255.
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        check("f1.busy", 32'(busy), 1);
        pix(1'b1, 1'b0, 1'b0, 8'd99);
        hist("f1.presof", 1'b0, 1'b0, 8'd0, 1'b0);
        check("f1.presof.iydata", 32'(iydata), 99);
        pix(1'b1, 1'b1, 1'b0, 8'd10);
        hist("f1.p0", 1'b1, 1'b1, 8'd10, 1'b0);
        check("f1.p0.rsig", 32'(rsig), 0);
        check("f1.p0.map_valid", 32'(map_valid), 0);
        pix(1'b1, 1'b0, 1'b0, 8'd20);
        hist("f1.p1", 1'b1, 1'b1, 8'd20, 1'b0);
        pix(1'b1, 1'b0, 1'b0, 8'd20);
        hist("f1.p2", 1'b1, 1'b1, 8'd20, 1'b0);
        pix(1'b1, 1'b0, 1'b1, 8'd255);
        hist("f1.p3", 1'b1, 1'b1, 8'd255, 1'b0);
        pix(1'b1, 1'b0, 1'b0, 8'd77);
        hist("f1.close", 1'b0, 1'b0, 8'd0, 1'b1);
`ifdef HISTEQ_CTRL_STAT_EN
        check("f1.pix_cnt", 32'(pix_cnt), 4);
`endif
        pix(1'b1, 1'b0, 1'b0, 8'd78);
        hist("f1.gap", 1'b0, 1'b0, 8'd0, 1'b0);
        check("f1.gap.rsig", 32'(rsig), 0);
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        hist("f1.post", 1'b0, 1'b0, 8'd0, 1'b0);
        check("f1.post.rsig", 32'(rsig), 1);

        // Frame 2: LUT valid, map_valid follows pix_valid.
        pix(1'b1, 1'b1, 1'b0, 8'd40);
        hist("f2.p0", 1'b1, 1'b1, 8'd40, 1'b0);
        check("f2.p0.map_valid", 32'(map_valid), 1);
        check("f2.p0.iydata", 32'(iydata), 40);
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        hist("f2.idle", 1'b1, 1'b0, 8'd0, 1'b0);
        check("f2.idle.map_valid", 32'(map_valid), 0);
        pix(1'b1, 1'b1, 1'b0, 8'd50);
        hist("f2.p1", 1'b1, 1'b1, 8'd50, 1'b0);
        check("f2.p1.map_valid", 32'(map_valid), 1);
        check("f2.p1.iydata", 32'(iydata), 50);
        pix(1'b1, 1'b0, 1'b1, 8'd60);
        hist("f2.p2", 1'b1, 1'b1, 8'd60, 1'b0);
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        hist("f2.close", 1'b0, 1'b0, 8'd0, 1'b1);
`ifdef HISTEQ_CTRL_STAT_EN
        check("f2.pix_cnt", 32'(pix_cnt), 3);
`endif
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        pix(1'b0, 1'b0, 1'b0, 8'd0);

        // One-pixel frame: sof and eof together.
        pix(1'b1, 1'b1, 1'b1, 8'd5);
        hist("one.p0", 1'b1, 1'b1, 8'd5, 1'b0);
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        hist("one.close", 1'b0, 1'b0, 8'd0, 1'b1);
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        hist("one.gap", 1'b0, 1'b0, 8'd0, 1'b0);
        pix(1'b0, 1'b0, 1'b0, 8'd0);

        // Forced close at MAX_PIX=5 on an 8-pixel frame without eof.
        for (int i = 1; i <= 8; i++) begin
            pix(1'b1, i == 1, 1'b0, 8'(i));
            if (i <= 5) hist($sformatf("max.p%0d", i), 1'b1, 1'b1, 8'(i), 1'b0);
            else hist($sformatf("max.p%0d", i), 1'b0, 1'b0, 8'd0, i == 6);
        end
`ifdef HISTEQ_CTRL_STAT_EN
        check("max.ovf", 32'(ovf), 1);
        check("max.pix_cnt", 32'(pix_cnt), 5);
`endif
        pix(1'b1, 1'b0, 1'b0, 8'd9);
        hist("max.nosof", 1'b0, 1'b0, 8'd0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        pix(1'b1, 1'b1, 1'b0, 8'd11);
        hist("rstm.p0", 1'b1, 1'b1, 8'd11, 1'b0);
        check("rstm.p0.rsig", 32'(rsig), 1);
        pix(1'b1, 1'b0, 1'b0, 8'd12);
        #2;
        erst = 1'b0;
        #1;
        hist("rstm.async", 1'b0, 1'b0, 8'd0, 1'b0);
        check("rstm.async.rsig", 32'(rsig), 0);
        check("rstm.async.busy", 32'(busy), 0);
        check("rstm.async.iydata", 32'(iydata), 0);
`ifdef HISTEQ_CTRL_STAT_EN
        check("rstm.async.ovf", 32'(ovf), 0);
`endif
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        check("rstm.held.frame_done", 32'(frame_done), 0);
        erst = 1'b1;
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        pix(1'b1, 1'b1, 1'b0, 8'd33);
        hist("rstm.next", 1'b1, 1'b1, 8'd33, 1'b0);
        check("rstm.next.rsig", 32'(rsig), 0);
        check("rstm.next.map_valid", 32'(map_valid), 0);
        pix(1'b1, 1'b0, 1'b1, 8'd34);
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        pix(1'b0, 1'b0, 1'b0, 8'd0);
        pix(1'b0, 1'b0, 1'b0, 8'd0);

        // enable low in WAIT_SOF: sof ignored, back to IDLE.
        enable = 1'b0;
        pix(1'b1, 1'b1, 1'b0, 8'd44);
        hist("dis.sof", 1'b0, 1'b0, 8'd0, 1'b0);
        check("dis.busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
